// File: rtl/usb_ep0_sequencer.sv
// EP0 control-transfer sequencer: captures SETUP, decodes via the lookup table,
// streams IN data from the descriptor ROM in MAX_PACKET chunks and runs the status stage.
module usb_ep0_sequencer #(
  parameter int MAX_PACKET = 8,
  parameter int ROM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usb_rst,
  input  logic              transaction_active,
  input  logic [3:0]        endpoint,
  input  logic              setup,
  input  logic              direction_in,
  input  logic              data_strobe,
  input  logic [7:0]        data_out,
  input  logic              success,
  output logic [7:0]        data_in,
  output logic              data_in_valid,
  output logic              data_toggle,
  output logic [1:0]        handshake,
  output logic [6:0]        usb_address,
  output logic [63:0]       setup_pkt,
  input  logic              lookup_valid,
  input  logic [ROM_AW-1:0] lookup_offset,
  input  logic [7:0]        lookup_len,
  input  logic              is_set_address,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data
);

  typedef enum logic [2:0] {
    IDLE, SETUP_RX, DECODE, DATA_IN, STATUS_OUT, STATUS_IN, STALL
  } state_t;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;
  localparam logic [7:0] MAXP     = 8'(MAX_PACKET);

  state_t            state;
  logic              ta_q;
  logic [3:0]        setup_cnt;
  logic [7:0]        remaining;
  logic [7:0]        init_len;
  logic [7:0]        sent;
  logic [ROM_AW-1:0] ptr;
  logic              set_addr_q;

  logic        ep0, rise, fall, setup_edge;
  logic [15:0] wlength;
  logic [7:0]  wlen8, rem0, pkt_cnt, rem_after;
  logic        need_zlp;

  assign ep0        = (endpoint == 4'd0);
  assign rise       = transaction_active & ~ta_q;
  assign fall       = ~transaction_active & ta_q;
  assign setup_edge = rise & setup & ep0;

  assign wlength   = setup_pkt[63:48];
  assign wlen8     = (setup_pkt[63:56] != 8'd0) ? 8'hFF : setup_pkt[55:48];
  assign rem0      = (wlen8 < lookup_len) ? wlen8 : lookup_len;
  assign pkt_cnt   = (remaining < MAXP) ? remaining : MAXP;
  assign rem_after = remaining - pkt_cnt;
  // A full final packet only ends the stage if the host asked for exactly that many bytes.
  assign need_zlp  = (pkt_cnt == MAXP) && ({8'd0, init_len} < wlength);

  assign rom_addr      = ptr + ROM_AW'(sent);
  assign data_in       = (state == DATA_IN) ? rom_data : '0;
  assign data_in_valid = (state == DATA_IN) && (sent < pkt_cnt);

  always_ff @(posedge clk) begin
    if (rst || usb_rst) begin
      state       <= IDLE;
      ta_q        <= 1'b0;
      setup_cnt   <= '0;
      remaining   <= '0;
      init_len    <= '0;
      sent        <= '0;
      ptr         <= '0;
      set_addr_q  <= 1'b0;
      data_toggle <= 1'b0;
      handshake   <= HS_ACK;
      usb_address <= '0;
      setup_pkt   <= '0;
    end else begin
      ta_q <= transaction_active;

      // Handshake is chosen when the token arrives and held for the transaction.
      if (!transaction_active) begin
        handshake <= (state == STALL) ? HS_STALL : HS_ACK;
      end else if (rise) begin
        if (setup && ep0)
          handshake <= HS_ACK;
        else if (!ep0)
          handshake <= HS_NAK;
        else begin
          case (state)
            STALL:                  handshake <= HS_STALL;
            IDLE, SETUP_RX, DECODE: handshake <= HS_NAK;
            default:                handshake <= HS_ACK;
          endcase
        end
      end

      if (setup_edge) begin
        state       <= SETUP_RX;
        setup_cnt   <= '0;
        sent        <= '0;
        data_toggle <= 1'b0;
      end else begin
        case (state)
          SETUP_RX: if (ep0) begin
            if (success)
              state <= (setup_cnt == 4'd8) ? DECODE : IDLE;
            else if (fall)
              state <= IDLE;
            else if (data_strobe && setup_cnt != 4'd8) begin
              setup_pkt[{setup_cnt[2:0], 3'b000} +: 8] <= data_out;
              setup_cnt <= setup_cnt + 4'd1;
            end
          end
          DECODE: begin
            set_addr_q <= is_set_address;
            sent       <= '0;
            if (!lookup_valid)
              state <= STALL;
            else if (setup_pkt[7] && rem0 != 8'd0) begin
              state       <= DATA_IN;
              data_toggle <= 1'b1;
              ptr         <= lookup_offset;
              remaining   <= rem0;
              init_len    <= rem0;
            end else if (!setup_pkt[7] && wlength != 16'd0)
              state <= STALL;
            else begin
              state       <= STATUS_IN;
              data_toggle <= 1'b1;
            end
          end
          DATA_IN: if (ep0) begin
            if (rise && !direction_in) begin
              state       <= STATUS_OUT;
              data_toggle <= 1'b1;
              sent        <= '0;
            end else if (success && direction_in) begin
              ptr         <= ptr + ROM_AW'(pkt_cnt);
              remaining   <= rem_after;
              data_toggle <= ~data_toggle;
              sent        <= '0;
              if (remaining == 8'd0 || (rem_after == 8'd0 && !need_zlp)) begin
                state       <= STATUS_OUT;
                data_toggle <= 1'b1;
              end
            end else if (fall)
              sent <= '0;
            else if (data_strobe && direction_in && transaction_active && sent < pkt_cnt)
              sent <= sent + 8'd1;
          end
          STATUS_OUT: if (ep0 && success && !direction_in) state <= IDLE;
          STATUS_IN: if (ep0 && success && direction_in) begin
            if (set_addr_q) usb_address <= setup_pkt[22:16];
            state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_ep0_sequencer.sv
// Bench for usb_ep0_sequencer: host-side transaction tasks with a byte scoreboard
// of expected ROM address/data pairs popped as the DUT streams IN data.
module tb_usb_ep0_sequencer;

  localparam logic [1:0] ACK = 2'b00, NAK = 2'b10, STL = 2'b11;

  logic        clk = 1'b0;
  logic        rst, usb_rst, transaction_active, setup, direction_in, data_strobe, success;
  logic [3:0]  endpoint;
  logic [7:0]  data_out, data_in, lookup_len, rom_data;
  logic        data_in_valid, data_toggle, lookup_valid, is_set_address;
  logic [1:0]  handshake;
  logic [6:0]  usb_address;
  logic [63:0] setup_pkt;
  logic [7:0]  lookup_offset, rom_addr;

  typedef struct { logic [7:0] addr; logic [7:0] data; } sb_item_t;
  sb_item_t sb[$];

  int   checks = 0;
  int   errors = 0;
  logic [6:0] addr_before, addr_after;

  usb_ep0_sequencer #(.MAX_PACKET(8), .ROM_AW(8)) dut (
    .clk(clk), .rst(rst), .usb_rst(usb_rst),
    .transaction_active(transaction_active), .endpoint(endpoint), .setup(setup),
    .direction_in(direction_in), .data_strobe(data_strobe), .data_out(data_out),
    .success(success), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_toggle(data_toggle), .handshake(handshake), .usb_address(usb_address),
    .setup_pkt(setup_pkt), .lookup_valid(lookup_valid), .lookup_offset(lookup_offset),
    .lookup_len(lookup_len), .is_set_address(is_set_address),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction
  assign rom_data = rom_fn(rom_addr);

  function automatic logic [63:0] mk_setup(input logic [7:0] bm, input logic [7:0] req,
                                           input logic [15:0] wval, input logic [15:0] widx,
                                           input logic [15:0] wlen);
    return {wlen, widx, wval, req, bm};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lookup(input logic v, input logic [7:0] off, input logic [7:0] len,
                            input logic sa);
    lookup_valid = v; lookup_offset = off; lookup_len = len; is_set_address = sa;
  endtask

  task automatic do_setup(input string tag, input logic [63:0] pkt);
    endpoint = 4'd0; direction_in = 1'b0; setup = 1'b1; transaction_active = 1'b1;
    tick; tick;
    check_eq({tag, ".hs"}, handshake, ACK);
    check_eq({tag, ".tog"}, data_toggle, 1'b0);
    for (int i = 0; i < 8; i++) begin
      data_out = pkt[i*8 +: 8];
      data_strobe = 1'b1;
      tick;
    end
    data_strobe = 1'b0;
    success = 1'b1;
    tick;
    success = 1'b0; transaction_active = 1'b0; setup = 1'b0;
    tick;
    check_eq({tag, ".pkt"}, setup_pkt, pkt);
  endtask

  // One host transaction; IN data is compared against the scoreboard as it streams.
  task automatic txn(input logic dir_in, input logic [3:0] ep, input int nbytes,
                     input logic [7:0] start, input logic [1:0] exp_hs, input logic exp_tog,
                     input logic ok, input string tag);
    int n = 0;
    sb_item_t it;
    for (int i = 0; i < nbytes; i++) begin
      it.addr = start + 8'(i);
      it.data = rom_fn(it.addr);
      sb.push_back(it);
    end
    endpoint = ep; direction_in = dir_in; setup = 1'b0; transaction_active = 1'b1;
    tick; tick;
    check_eq({tag, ".hs"}, handshake, exp_hs);
    if (exp_hs == ACK) begin
      check_eq({tag, ".tog"}, data_toggle, exp_tog);
      if (dir_in) begin
        while (data_in_valid && n < 80) begin
          if (sb.size() == 0) begin
            check_eq({tag, ".extra"}, n + 1, nbytes);
            break;
          end
          it = sb.pop_front();
          check_eq({tag, ".addr"}, rom_addr, it.addr);
          check_eq({tag, ".data"}, data_in, it.data);
          n++;
          data_strobe = 1'b1;
          tick;
        end
        data_strobe = 1'b0;
        check_eq({tag, ".len"}, n, nbytes);
      end
    end
    sb.delete();
    addr_before = usb_address;
    if (ok) begin
      success = 1'b1;
      tick;
      success = 1'b0;
    end
    addr_after = usb_address;
    transaction_active = 1'b0;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; usb_rst = 1'b0; transaction_active = 1'b0; setup = 1'b0;
    direction_in = 1'b0; data_strobe = 1'b0; success = 1'b0; endpoint = 4'd0;
    data_out = 8'd0;
    set_lookup(1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check_eq("rst.addr", usb_address, 0);
    check_eq("rst.tog", data_toggle, 0);
    check_eq("rst.hs", handshake, ACK);
    check_eq("rst.valid", data_in_valid, 0);
    check_eq("rst.data", data_in, 0);
    check_eq("rst.pkt", setup_pkt, 0);

    // GET_DESCRIPTOR, 18-byte response: 8, 8, 2 with a foreign-endpoint token in between.
    set_lookup(1'b1, 8'h20, 8'd18, 1'b0);
    do_setup("t1", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64));
    txn(1, 4'd0, 8, 8'h20, ACK, 1, 1, "t1.p1");
    txn(1, 4'd2, 0, 8'h00, NAK, 0, 0, "t1.ep2");
    txn(1, 4'd0, 8, 8'h28, ACK, 0, 1, "t1.p2");
    txn(1, 4'd0, 2, 8'h30, ACK, 1, 1, "t1.p3");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "t1.st");
    txn(1, 4'd0, 0, 8'h00, NAK, 0, 0, "t1.idle");

    // SET_ADDRESS 5: address appears only at the status-IN success.
    set_lookup(1'b1, 8'h00, 8'd0, 1'b1);
    do_setup("t2", mk_setup(8'h00, 8'h05, 16'h0005, 16'h0000, 16'd0));
    check_eq("t2.addr_decode", usb_address, 0);
    txn(1, 4'd0, 0, 8'h00, ACK, 1, 1, "t2.st");
    check_eq("t2.addr_pre", addr_before, 0);
    check_eq("t2.addr_post", addr_after, 5);

    // Response is an exact multiple of MAX_PACKET and shorter than wLength: ZLP follows.
    set_lookup(1'b1, 8'h40, 8'd16, 1'b0);
    do_setup("t3", mk_setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd64));
    txn(1, 4'd0, 8, 8'h40, ACK, 1, 1, "t3.p1");
    txn(1, 4'd0, 8, 8'h48, ACK, 0, 1, "t3.p2");
    txn(1, 4'd0, 0, 8'h00, ACK, 1, 1, "t3.zlp");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "t3.st");

    // wLength above 255 clamps rather than truncating to its low byte.
    set_lookup(1'b1, 8'h50, 8'd10, 1'b0);
    do_setup("tc", mk_setup(8'h80, 8'h06, 16'h0300, 16'h0000, 16'h0100));
    txn(1, 4'd0, 8, 8'h50, ACK, 1, 1, "tc.p1");
    txn(1, 4'd0, 2, 8'h58, ACK, 0, 1, "tc.p2");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "tc.st");

    // Packet 2 times out and is resent unchanged.
    set_lookup(1'b1, 8'h60, 8'd18, 1'b0);
    do_setup("t4", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64));
    txn(1, 4'd0, 8, 8'h60, ACK, 1, 1, "t4.p1");
    txn(1, 4'd0, 8, 8'h68, ACK, 0, 0, "t4.p2fail");
    txn(1, 4'd0, 8, 8'h68, ACK, 0, 1, "t4.p2retry");
    txn(1, 4'd0, 2, 8'h70, ACK, 1, 1, "t4.p3");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "t4.st");

    // Unsupported request stalls until the next SETUP; wLength equal to one packet needs no ZLP.
    set_lookup(1'b0, 8'h00, 8'd0, 1'b0);
    do_setup("t5", mk_setup(8'h80, 8'h06, 16'h0F00, 16'h0000, 16'd64));
    txn(1, 4'd0, 0, 8'h00, STL, 0, 0, "t5.in");
    txn(0, 4'd0, 0, 8'h00, STL, 0, 0, "t5.out");
    set_lookup(1'b1, 8'h80, 8'd18, 1'b0);
    do_setup("t5b", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd8));
    txn(1, 4'd0, 8, 8'h80, ACK, 1, 1, "t5b.p1");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "t5b.st");

    // Host cuts the data stage short with an early status OUT.
    set_lookup(1'b1, 8'hA0, 8'd18, 1'b0);
    do_setup("te", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64));
    txn(1, 4'd0, 8, 8'hA0, ACK, 1, 1, "te.p1");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "te.st");
    txn(1, 4'd0, 0, 8'h00, NAK, 0, 0, "te.idle");

    // New SETUP in the middle of the data stage restarts cleanly.
    set_lookup(1'b1, 8'hB0, 8'd18, 1'b0);
    do_setup("t6", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64));
    txn(1, 4'd0, 8, 8'hB0, ACK, 1, 1, "t6.p1");
    set_lookup(1'b1, 8'h90, 8'd18, 1'b0);
    do_setup("t6b", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd8));
    txn(1, 4'd0, 8, 8'h90, ACK, 1, 1, "t6b.p1");
    txn(0, 4'd0, 0, 8'h00, ACK, 1, 1, "t6b.st");

    // Bus reset mid-transfer drops the address and the transfer.
    check_eq("t6r.addr_pre", usb_address, 5);
    set_lookup(1'b1, 8'hC0, 8'd18, 1'b0);
    do_setup("t6r", mk_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64));
    txn(1, 4'd0, 8, 8'hC0, ACK, 1, 1, "t6r.p1");
    usb_rst = 1'b1;
    tick;
    usb_rst = 1'b0;
    check_eq("t6r.addr", usb_address, 0);
    check_eq("t6r.valid", data_in_valid, 0);
    check_eq("t6r.tog", data_toggle, 0);
    check_eq("t6r.hs", handshake, ACK);
    txn(1, 4'd0, 0, 8'h00, NAK, 0, 0, "t6r.idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_ep0_sequencer.md
Name: usb_ep0_sequencer

Overview:
Control-endpoint (EP0) transfer sequencer between the `usb` protocol core and the descriptor ROM.
- Captures the 8-byte SETUP packet and decodes it through an external descriptor-lookup table.
- Runs the data and status stages: packetizes IN data into MAX_PACKET chunks, manages DATA0/DATA1 toggles and handshakes, retries failed packets, and commits SET_ADDRESS.
- Replaces ad-hoc setup-stage sequencing in `buffered_usb`.

Parameters:
MAX_PACKET, 8, EP0 max packet size in bytes (8/16/32/64).
ROM_AW, 8, descriptor ROM address width.

Ports:
clk  in  1  48 MHz clock
rst  in  1  synchronous active-high reset
usb_rst  in  1  bus reset from usb core; same effect as rst
transaction_active  in  1  usb core: token accepted, transaction in progress
endpoint  in  4  usb core: token endpoint
setup  in  1  usb core: current transaction is SETUP
direction_in  in  1  usb core: IN transaction
data_strobe  in  1  usb core: byte consumed (IN) / byte received (OUT/SETUP)
data_out  in  8  usb core: received byte
success  in  1  usb core: pulse, transaction completed OK (CRC good / host ACK)
data_in  out  8  byte to transmit
data_in_valid  out  1  more bytes remain in current IN packet
data_toggle  out  1  PID toggle for current transaction
handshake  out  2  00 ack, 01 none, 10 nak, 11 stall
usb_address  out  7  committed device address
setup_pkt  out  64  captured SETUP bytes, byte0 in [7:0]
lookup_valid  in  1  lookup table: request supported
lookup_offset  in  ROM_AW  lookup table: ROM start of response
lookup_len  in  8  lookup table: response length
is_set_address  in  1  lookup table: request is SET_ADDRESS
rom_addr  out  ROM_AW  descriptor ROM address
rom_data  in  8  ROM data, combinational from rom_addr

Behaviour:
- Reset (rst or usb_rst, sampled each clk):
  - State IDLE; usb_address=0; data_toggle=0; handshake=ack; data_in_valid=0; data_in=0; setup_pkt=0.
  - All internal counters are cleared.
- EP0 scope: only endpoint==0 is handled. For any other endpoint, handshake=nak and state is unchanged.
- States: IDLE, SETUP_RX, DECODE, DATA_IN, STATUS_OUT, STATUS_IN, STALL.
- SETUP capture:
  - A rising edge of transaction_active with setup=1 enters SETUP_RX from any state, aborting any transfer in progress.
  - On entry: byte count cleared, handshake=ack, data_toggle=0.
  - Each data_strobe writes data_out into setup_pkt byte[count]; count saturates at 8.
- SETUP_RX exit:
  - success with count==8 -> DECODE.
  - transaction_active falling without success, or count!=8 -> IDLE.
- DECODE (1 cycle), lookup inputs sampled:
  - remaining = min(wLength, lookup_len), where wLength = {byte7, byte6}; a wLength above 255 clamps to 255.
  - !lookup_valid -> STALL.
  - bmRequestType[7]=1 and remaining>0 -> DATA_IN, with toggle=1 and ptr=lookup_offset.
  - Host-to-device request with wLength>0 (OUT data stage) -> STALL.
  - Otherwise -> STATUS_IN.
- DATA_IN:
  - On an IN transaction: pkt_cnt=min(remaining, MAX_PACKET).
  - rom_addr = ptr + sent; data_in = rom_data; data_in_valid = (sent < pkt_cnt).
  - Each data_strobe increments sent; ptr arithmetic wraps modulo 2^ROM_AW.
  - On success: ptr += pkt_cnt, remaining -= pkt_cnt, toggle flips, sent=0.
  - Transaction end without success: sent=0, ptr and toggle unchanged, so the same packet is resent.
  - remaining==0 after success:
    - Last packet was exactly MAX_PACKET and total sent < wLength -> one further zero-length packet (data_in_valid=0, toggle continues), then STATUS_OUT.
    - Otherwise -> STATUS_OUT.
  - An OUT transaction during DATA_IN (host early status) is treated as STATUS_OUT immediately.
- STATUS_OUT: data_toggle=1, handshake=ack; success -> IDLE.
- STATUS_IN: zero-length IN packet, data_toggle=1, data_in_valid=0.
  - On success, if is_set_address was latched in DECODE: usb_address = setup_pkt byte2[6:0], committed in that same cycle; never earlier.
  - Then -> IDLE.
- STALL: handshake=stall on every non-SETUP EP0 transaction until the next SETUP.
- IDLE: handshake=ack; EP0 IN/OUT tokens outside a transfer get nak.
- Simultaneous events: SETUP edge beats success in the same cycle; rst/usb_rst beat everything.

Test Plan:
1. GET_DESCRIPTOR(device) wLength=64, lookup_len=18, MAX_PACKET=8 -> IN packets 8, 8, 2 bytes with toggles 1, 0, 1; ROM addresses offset..offset+17 in order; status OUT acked with toggle 1; state IDLE.
2. SET_ADDRESS value 0x05 -> usb_address stays 0 through SETUP and DECODE; becomes 5 exactly on the status-IN success cycle.
3. wLength=64, lookup_len=16 -> packets 8, 8, then a ZLP with toggle 1, then status OUT.
4. IN packet 2 ends without success (host timeout) -> retry resends bytes 8..15 with toggle 0; the next success advances to packet 3.
5. lookup_valid=0 -> stall on subsequent IN and OUT; a new SETUP is acked and clears the stall.
6. New SETUP mid-DATA_IN, and a separate run with usb_rst mid-transfer -> SETUP restarts capture with toggle 0; usb_rst gives address 0, state IDLE, data_in_valid=0.
